// File: rtl/translator_axil_slave.sv
// AXI4-Lite register responder for the Translator core: NUM_REGS 32-bit control registers,
// exposed in parallel on reg_q. Optional macro AXIL_SLVERR_EN: out-of-range accesses answer SLVERR.
module translator_axil_slave #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_W-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_W-1:0]          S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]        S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_W-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_q
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [31:0] NUM_REGS_U = NUM_REGS;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  typedef enum logic {R_IDLE, R_RESP} rd_state_t;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              aw_full, w_full;
  logic [IDX_W-1:0]  aw_idx;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              aw_hs, w_hs, commit, aw_in_range;

  rd_state_t         rd_state, rd_next;
  logic              ar_hs, ar_in_range;
  logic [IDX_W-1:0]  ar_idx;
  logic [DATA_W-1:0] rd_word, rdata;
  logic [1:0]        rresp;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write path: one-entry AW and W slots, committed together once the B slot can take a response
  assign S_AXI_AWREADY = ~aw_full;
  assign S_AXI_WREADY  = ~w_full;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;

  assign aw_hs       = S_AXI_AWVALID & ~aw_full;
  assign w_hs        = S_AXI_WVALID & ~w_full;
  assign commit      = aw_full & w_full & (~bvalid | S_AXI_BREADY);
  assign aw_in_range = (32'(aw_idx) < NUM_REGS_U);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[ADDR_W-1:2];
      end else if (commit) begin
        aw_full <= 1'b0;
      end

      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end else if (commit) begin
        w_full <= 1'b0;
      end

      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= aw_in_range ? RESP_OKAY : RESP_OOR;
      end else if (S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Out-of-range indices match no register, so they leave the file untouched
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (32'(aw_idx) == 32'(i) && w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[DATA_W*i +: DATA_W] = regs[i];
  end

  // Read path
  assign ar_idx      = S_AXI_ARADDR[ADDR_W-1:2];
  assign ar_in_range = (32'(ar_idx) < NUM_REGS_U);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(ar_idx) == 32'(i)) rd_word = regs[i];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rd_state <= R_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next       = rd_state;
    ar_hs         = 1'b0;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        S_AXI_ARREADY = 1'b1;
        if (S_AXI_ARVALID) begin
          ar_hs   = 1'b1;
          rd_next = R_RESP;
        end
      end
      R_RESP: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Data is captured from the pre-edge register values, so a same-edge commit reads old data
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata <= rd_word;
      rresp <= ar_in_range ? RESP_OKAY : RESP_OOR;
    end
  end

  assign S_AXI_RDATA = rdata;
  assign S_AXI_RRESP = rresp;

endmodule

// File: tb/tb_translator_axil_slave.sv
// Self-checking bench for translator_axil_slave: table-driven AXI-Lite accesses with a
// response scoreboard, plus hand-written sequences for the multi-cycle corner cases.
module tb_translator_axil_slave;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int NUM_REGS = 4;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic                       ACLK, ARESET;
  logic [ADDR_W-1:0]          S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]                 S_AXI_AWPROT, S_AXI_ARPROT;
  logic                       S_AXI_AWVALID, S_AXI_AWREADY;
  logic [DATA_W-1:0]          S_AXI_WDATA;
  logic [DATA_W/8-1:0]        S_AXI_WSTRB;
  logic                       S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]                 S_AXI_BRESP, S_AXI_RRESP;
  logic                       S_AXI_BVALID, S_AXI_BREADY;
  logic                       S_AXI_ARVALID, S_AXI_ARREADY;
  logic [DATA_W-1:0]          S_AXI_RDATA;
  logic                       S_AXI_RVALID, S_AXI_RREADY;
  logic [NUM_REGS*DATA_W-1:0] reg_q;

  translator_axil_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_q(reg_q)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [NUM_REGS];

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    logic [1:0]  resp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        is_rd;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=handshake", name);
  endtask

  function automatic logic [127:0] model_q();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic apply_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr[5:2]);
    if (idx < NUM_REGS) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_aw(input logic [5:0] addr);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    S_AXI_AWADDR  = addr;
    S_AXI_AWVALID = 1'b1;
    while (!ok && n < 100) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) ok = 1;
      else n++;
    end
    if (!ok) timeout("aw_ready");
    tick();
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    int n;
    bit ok;
    n = 0;
    ok = 0;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    S_AXI_WVALID = 1'b1;
    while (!ok && n < 100) begin
      @(negedge ACLK);
      if (S_AXI_WREADY) ok = 1;
      else n++;
    end
    if (!ok) timeout("w_ready");
    tick();
    S_AXI_WVALID = 1'b0;
  endtask

  task automatic pop_and_check(input bit is_rd);
    sb_t e;
    if (sb_q.size() == 0) begin
      timeout("scoreboard_empty");
    end else begin
      e = sb_q.pop_front();
      if (is_rd) begin
        chk("rdata", S_AXI_RDATA, e.data);
        chk("rresp", 32'(S_AXI_RRESP), 32'(e.resp));
      end else begin
        chk("bresp", 32'(S_AXI_BRESP), 32'(e.resp));
      end
    end
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    int n;
    bit ok;
    sb_q.push_back('{1'b0, 32'h0, exp_resp});
    apply_write(addr, data, strb);
    fork
      send_aw(addr);
      send_w(data, strb);
    join
    n = 0;
    ok = 0;
    while (!ok && n < 100) begin
      @(negedge ACLK);
      if (S_AXI_BVALID) ok = 1;
      else n++;
    end
    if (!ok) timeout("bvalid");
    else pop_and_check(1'b0);
    tick();
    chk_q("reg_q_after_write", reg_q, model_q());
  endtask

  task automatic do_read(input logic [5:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n;
    bit ok;
    sb_q.push_back('{1'b1, exp_data, exp_resp});
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    ok = 0;
    while (!ok && n < 100) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) ok = 1;
      else n++;
    end
    if (!ok) timeout("ar_ready");
    tick();
    S_AXI_ARVALID = 1'b0;
    chk("rd_latency_rvalid", 32'(S_AXI_RVALID), 1);
    n = 0;
    ok = 0;
    while (!ok && n < 100) begin
      @(negedge ACLK);
      if (S_AXI_RVALID) ok = 1;
      else n++;
    end
    if (!ok) timeout("rvalid");
    else pop_and_check(1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back('{1'b0, 6'h00, 32'h0101FFFF, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 6'h04, 32'hABCD0001, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 6'h08, 32'hDEAD0011, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 6'h0C, 32'hBEEF0011, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b1, 6'h00, 32'h0, 4'h0, 32'h0101FFFF, 2'b00});
    vecs.push_back('{1'b1, 6'h04, 32'h0, 4'h0, 32'hABCD0001, 2'b00});
    vecs.push_back('{1'b1, 6'h08, 32'h0, 4'h0, 32'hDEAD0011, 2'b00});
    vecs.push_back('{1'b1, 6'h0C, 32'h0, 4'h0, 32'hBEEF0011, 2'b00});
    vecs.push_back('{1'b1, 6'h07, 32'h0, 4'h0, 32'hABCD0001, 2'b00});
    vecs.push_back('{1'b0, 6'h10, 32'h12345678, 4'hF, 32'h0, OOR});
    vecs.push_back('{1'b1, 6'h10, 32'h0, 4'h0, 32'h0, OOR});
    vecs.push_back('{1'b0, 6'h3C, 32'hCAFEF00D, 4'hF, 32'h0, OOR});
    vecs.push_back('{1'b1, 6'h3C, 32'h0, 4'h0, 32'h0, OOR});
    vecs.push_back('{1'b1, 6'h00, 32'h0, 4'h0, 32'h0101FFFF, 2'b00});
    vecs.push_back('{1'b0, 6'h00, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00});
    vecs.push_back('{1'b0, 6'h00, 32'h00AA0000, 4'h4, 32'h0, 2'b00});
    vecs.push_back('{1'b1, 6'h00, 32'h0, 4'h0, 32'hFFAAFFFF, 2'b00});
    vecs.push_back('{1'b0, 6'h0C, 32'h11223344, 4'h3, 32'h0, 2'b00});
    vecs.push_back('{1'b1, 6'h0C, 32'h0, 4'h0, 32'hBEEF3344, 2'b00});

    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = 3'b000; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'b000; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    repeat (3) tick();

    chk("rst_awready", 32'(S_AXI_AWREADY), 1);
    chk("rst_wready", 32'(S_AXI_WREADY), 1);
    chk("rst_arready", 32'(S_AXI_ARREADY), 1);
    chk("rst_bvalid", 32'(S_AXI_BVALID), 0);
    chk("rst_rvalid", 32'(S_AXI_RVALID), 0);
    chk("rst_bresp", 32'(S_AXI_BRESP), 0);
    chk("rst_rresp", 32'(S_AXI_RRESP), 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk_q("rst_reg_q", reg_q, 128'h0);
    ARESET = 1'b0;
    tick();

    foreach (vecs[i]) begin
      if (vecs[i].is_rd) do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
      else do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
    end

    // Same-cycle AW+W: BVALID and reg_q one edge after the handshake
    S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h13579BDF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("lat_bvalid_early", 32'(S_AXI_BVALID), 0);
    chk("lat_awready_full", 32'(S_AXI_AWREADY), 0);
    chk("lat_reg1_old", reg_q[63:32], 32'hABCD0001);
    tick();
    chk("lat_bvalid", 32'(S_AXI_BVALID), 1);
    chk("lat_reg1_new", reg_q[63:32], 32'h13579BDF);
    tick();
    chk("lat_bvalid_clr", 32'(S_AXI_BVALID), 0);
    model[1] = 32'h13579BDF;

    // AW three cycles ahead of W
    S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    chk("awfirst_awready", 32'(S_AXI_AWREADY), 0);
    for (int c = 0; c < 3; c++) begin
      chk("awfirst_no_b", 32'(S_AXI_BVALID), 0);
      tick();
    end
    S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    chk("awfirst_b_wait", 32'(S_AXI_BVALID), 0);
    tick();
    chk("awfirst_bvalid", 32'(S_AXI_BVALID), 1);
    tick();
    chk("awfirst_single_b", 32'(S_AXI_BVALID), 0);
    model[1] = 32'h12345678;
    do_read(6'h04, 32'h12345678, 2'b00);

    // W three cycles ahead of AW
    S_AXI_WDATA = 32'h2468ACE0; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    chk("wfirst_wready", 32'(S_AXI_WREADY), 0);
    for (int c = 0; c < 3; c++) begin
      chk("wfirst_no_b", 32'(S_AXI_BVALID), 0);
      tick();
    end
    S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    chk("wfirst_b_wait", 32'(S_AXI_BVALID), 0);
    tick();
    chk("wfirst_bvalid", 32'(S_AXI_BVALID), 1);
    tick();
    chk("wfirst_single_b", 32'(S_AXI_BVALID), 0);
    model[1] = 32'h2468ACE0;
    do_read(6'h04, 32'h2468ACE0, 2'b00);

    // B back-pressure with a second write queued in the slots
    S_AXI_BREADY = 1'b0;
    S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h0A0A0A0A; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WDATA = 32'h0B0B0B0B;
    tick();
    chk("bp_first_bvalid", 32'(S_AXI_BVALID), 1);
    chk("bp_first_reg1", reg_q[63:32], 32'h0A0A0A0A);
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    repeat (5) tick();
    chk("bp_awready", 32'(S_AXI_AWREADY), 0);
    chk("bp_wready", 32'(S_AXI_WREADY), 0);
    chk("bp_bvalid_held", 32'(S_AXI_BVALID), 1);
    chk("bp_reg1_held", reg_q[63:32], 32'h0A0A0A0A);
    S_AXI_BREADY = 1'b1;
    tick();
    chk("bp_second_bvalid", 32'(S_AXI_BVALID), 1);
    chk("bp_second_reg1", reg_q[63:32], 32'h0B0B0B0B);
    chk("bp_slots_free", 32'(S_AXI_AWREADY), 1);
    tick();
    chk("bp_bvalid_clr", 32'(S_AXI_BVALID), 0);
    model[1] = 32'h0B0B0B0B;

    // Read and commit to the same register on the same edge
    S_AXI_AWADDR = 6'h08; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h55555555; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    tick();
    S_AXI_ARVALID = 1'b0;
    chk("same_rvalid", 32'(S_AXI_RVALID), 1);
    chk("same_rdata_old", S_AXI_RDATA, 32'hDEAD0011);
    chk("same_bvalid", 32'(S_AXI_BVALID), 1);
    chk("same_reg2_new", reg_q[95:64], 32'h55555555);
    S_AXI_RREADY = 1'b1;
    tick();
    chk("same_rvalid_clr", 32'(S_AXI_RVALID), 0);
    model[2] = 32'h55555555;
    do_read(6'h08, 32'h55555555, 2'b00);

    // Reset while a read response is outstanding
    S_AXI_RREADY = 1'b0;
    S_AXI_ARADDR = 6'h0C; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    chk("rstmid_rvalid", 32'(S_AXI_RVALID), 1);
    chk("rstmid_rdata", S_AXI_RDATA, 32'hBEEF3344);
    #2;
    ARESET = 1'b1;
    #1;
    chk("rstmid_rvalid_clr", 32'(S_AXI_RVALID), 0);
    chk("rstmid_arready", 32'(S_AXI_ARREADY), 1);
    chk("rstmid_rdata_clr", S_AXI_RDATA, 0);
    chk_q("rstmid_reg_q", reg_q, 128'h0);
    tick();
    ARESET = 1'b0;
    S_AXI_RREADY = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    tick();
    do_read(6'h0C, 32'h0, 2'b00);
    do_write(6'h00, 32'h00000001, 4'hF, 2'b00);
    do_read(6'h00, 32'h00000001, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
